// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the accumulator-machine control unit and its
// datapath: state encodings, opcode map, A-input select codes and the
// packed control word produced by the output decoder.
// ---------------------------------------------------------------------------
package cu_pkg;

    localparam int OP_W    = 3;
    localparam int ASEL_W  = 2;
    localparam int STATE_W = 4;

    // Execute states sit at 8 + opcode so DECODE can jump with {1'b1, op}.
    typedef enum logic [STATE_W-1:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd8,
        ST_STORE  = 4'd9,
        ST_ADD    = 4'd10,
        ST_SUB    = 4'd11,
        ST_INPUT  = 4'd12,
        ST_JZ     = 4'd13,
        ST_JPOS   = 4'd14,
        ST_HALT   = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OP_W-1:0] OP_STORE = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OP_W-1:0] OP_INPUT = 3'b100;
    localparam logic [OP_W-1:0] OP_JZ    = 3'b101;
    localparam logic [OP_W-1:0] OP_JPOS  = 3'b110;
    localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

    localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
    localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
    localparam logic [ASEL_W-1:0] ASEL_MEM = 2'b10;

    typedef struct packed {
        logic              irload;
        logic              jmpmux;
        logic              pcload;
        logic              meminst;
        logic              memwr;
        logic              aload;
        logic              sub;
        logic [ASEL_W-1:0] asel;
        logic              halt;
    } ctrl_t;

    // Execute state reached from DECODE for a given opcode.
    function automatic state_t exec_state(input logic [OP_W-1:0] op);
        return state_t'({1'b1, op});
    endfunction

endpackage

// File: rtl/cu_output_decode.sv
// ---------------------------------------------------------------------------
// cu_output_decode
// Combinational state -> control-word decoder for the control unit.
// Every strobe defaults to 0; each state raises only what it needs.
// Ports:
//   i_state  current registered state
//   i_aeq0   accumulator == 0 (qualifies PCload in JZ)
//   i_apos   accumulator > 0  (qualifies PCload in JPOS)
//   i_in_go  INPUT may load the accumulator this cycle
//   o_ctrl   packed control word
// ---------------------------------------------------------------------------
module cu_output_decode
    import cu_pkg::*;
(
    input  state_t i_state,
    input  logic   i_aeq0,
    input  logic   i_apos,
    input  logic   i_in_go,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.irload = 1'b1;
                o_ctrl.pcload = 1'b1;
            end
            ST_DECODE: begin
                o_ctrl.meminst = 1'b1;
            end
            ST_LOAD: begin
                o_ctrl.meminst = 1'b1;
                o_ctrl.asel    = ASEL_MEM;
                o_ctrl.aload   = 1'b1;
            end
            ST_STORE: begin
                o_ctrl.meminst = 1'b1;
                o_ctrl.memwr   = 1'b1;
            end
            ST_ADD: begin
                o_ctrl.meminst = 1'b1;
                o_ctrl.asel    = ASEL_ALU;
                o_ctrl.aload   = 1'b1;
            end
            ST_SUB: begin
                o_ctrl.meminst = 1'b1;
                o_ctrl.asel    = ASEL_ALU;
                o_ctrl.sub     = 1'b1;
                o_ctrl.aload   = 1'b1;
            end
            ST_INPUT: begin
                o_ctrl.asel  = ASEL_IN;
                o_ctrl.aload = i_in_go;
            end
            ST_JZ: begin
                o_ctrl.jmpmux = 1'b1;
                o_ctrl.pcload = i_aeq0;
            end
            ST_JPOS: begin
                o_ctrl.jmpmux = 1'b1;
                o_ctrl.pcload = i_apos;
            end
            ST_HALT: begin
                o_ctrl.halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore FSM sequencing the 8-bit accumulator datapath:
// FETCH -> DECODE -> execute, 3 cycles per instruction; HALT until reset.
// Optional macro CU_INPUT_WAIT_EN: INPUT waits for the enter strobe and
// then loads the accumulator exactly once before returning to FETCH.
// Ports:
//   clock, reset      clock; synchronous active-high reset (-> START)
//   IR75              opcode, sampled only in DECODE
//   Aeq0, Apos        accumulator status flags
//   enter             operator strobe (used only with CU_INPUT_WAIT_EN)
//   IRload..Asel      datapath control strobes
//   halt              high in HALT
//   state             current state code for debug display
// ---------------------------------------------------------------------------
module control_unit
    import cu_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int ASEL_W  = 2,
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [OP_W-1:0]    IR75,
    input  logic               Aeq0,
    input  logic               Apos,
    input  logic               enter,
    output logic               IRload,
    output logic               JMPmux,
    output logic               PCload,
    output logic               Meminst,
    output logic               MemWr,
    output logic               Aload,
    output logic               Sub,
    output logic [ASEL_W-1:0]  Asel,
    output logic               halt,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    logic   w_in_go;
    ctrl_t  w_ctrl;

`ifdef CU_INPUT_WAIT_EN
    // Set once enter is seen in INPUT; the following INPUT cycle loads A.
    logic r_in_go;
    assign w_in_go = r_in_go;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_START;
            r_in_go <= 1'b0;
        end else begin
            case (r_state)
                ST_START:  r_state <= ST_FETCH;
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= exec_state(IR75);
                ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_JZ, ST_JPOS:
                           r_state <= ST_FETCH;
                ST_INPUT: begin
                    if (r_in_go) begin
                        r_in_go <= 1'b0;
                        r_state <= ST_FETCH;
                    end else if (enter) begin
                        r_in_go <= 1'b1;
                    end
                end
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_START;
            endcase
        end
    end
`else
    // enter is deliberately ignored in this build.
    logic w_unused_enter;
    assign w_unused_enter = enter;
    assign w_in_go        = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_START;
        end else begin
            case (r_state)
                ST_START:  r_state <= ST_FETCH;
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= exec_state(IR75);
                ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_INPUT, ST_JZ, ST_JPOS:
                           r_state <= ST_FETCH;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_START;
            endcase
        end
    end
`endif

    cu_output_decode u_decode (
        .i_state (r_state),
        .i_aeq0  (Aeq0),
        .i_apos  (Apos),
        .i_in_go (w_in_go),
        .o_ctrl  (w_ctrl)
    );

    assign IRload  = w_ctrl.irload;
    assign JMPmux  = w_ctrl.jmpmux;
    assign PCload  = w_ctrl.pcload;
    assign Meminst = w_ctrl.meminst;
    assign MemWr   = w_ctrl.memwr;
    assign Aload   = w_ctrl.aload;
    assign Sub     = w_ctrl.sub;
    assign Asel    = w_ctrl.asel;
    assign halt    = w_ctrl.halt;
    assign state   = r_state;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed self-checking bench for control_unit. Outputs are sampled on the
// falling edge; inputs change just after it. The strobe vector is
// {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel[1:0],halt}.
// ---------------------------------------------------------------------------
module tb_control_unit;
    import cu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] IR75;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
    logic [1:0] Asel;
    logic [3:0] state;
    logic [9:0] vec;

    int n_checks = 0;
    int n_fail   = 0;

    assign vec = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halt};

    control_unit dut (
        .clock   (clock),
        .reset   (reset),
        .IR75    (IR75),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .enter   (enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Aload   (Aload),
        .Sub     (Sub),
        .Asel    (Asel),
        .halt    (halt),
        .state   (state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // From FETCH: present the opcode through DECODE and land in execute.
    task automatic goto_exec(input logic [2:0] op);
        IR75 = op;
        tick();
        tick();
        IR75 = 3'b111;
    endtask

    task automatic test_reset();
        reset = 1'b1; IR75 = 3'b000; Aeq0 = 1'b1; Apos = 1'b1; enter = 1'b0;
        @(negedge clock);
        tick();
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++;
        if (vec !== 10'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected %b", vec, 10'b0); end
        reset = 1'b0;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL release_start: got %0d expected 0", state); end
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL fetch_state: got %0d expected 1", state); end
        n_checks++;
        if (vec !== 10'b1010000000) begin n_fail++; $display("FAIL fetch_strobes: got %b expected %b", vec, 10'b1010000000); end
    endtask

    task automatic test_load();
        IR75 = OP_LOAD;
        tick();
        n_checks++;
        if (state !== 4'd2 || vec !== 10'b0001000000) begin
            n_fail++; $display("FAIL decode: got state %0d vec %b expected 2 %b", state, vec, 10'b0001000000);
        end
        tick();
        IR75 = 3'b111;
        n_checks++;
        if (state !== 4'd8 || vec !== 10'b0001010100) begin
            n_fail++; $display("FAIL load: got state %0d vec %b expected 8 %b", state, vec, 10'b0001010100);
        end
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL load_to_fetch: got %0d expected 1", state); end
    endtask

    task automatic test_jumps();
        Aeq0 = 1'b1; Apos = 1'b0;
        goto_exec(OP_JZ);
        n_checks++;
        if (state !== 4'd13 || vec !== 10'b0110000000) begin
            n_fail++; $display("FAIL jz_taken: got state %0d vec %b expected 13 %b", state, vec, 10'b0110000000);
        end
        tick();
        Aeq0 = 1'b0; Apos = 1'b1;
        goto_exec(OP_JZ);
        n_checks++;
        if (state !== 4'd13 || vec !== 10'b0100000000) begin
            n_fail++; $display("FAIL jz_not_taken: got state %0d vec %b expected 13 %b", state, vec, 10'b0100000000);
        end
        tick();
        goto_exec(OP_JPOS);
        n_checks++;
        if (state !== 4'd14 || vec !== 10'b0110000000) begin
            n_fail++; $display("FAIL jpos_taken: got state %0d vec %b expected 14 %b", state, vec, 10'b0110000000);
        end
        tick();
        Aeq0 = 1'b1; Apos = 1'b0;
        goto_exec(OP_JPOS);
        n_checks++;
        if (state !== 4'd14 || vec !== 10'b0100000000) begin
            n_fail++; $display("FAIL jpos_not_taken: got state %0d vec %b expected 14 %b", state, vec, 10'b0100000000);
        end
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL jump_to_fetch: got %0d expected 1", state); end
    endtask

    task automatic test_alu_store();
        goto_exec(OP_SUB);
        n_checks++;
        if (state !== 4'd11 || vec !== 10'b0001011000) begin
            n_fail++; $display("FAIL sub: got state %0d vec %b expected 11 %b", state, vec, 10'b0001011000);
        end
        tick();
        goto_exec(OP_ADD);
        n_checks++;
        if (state !== 4'd10 || vec !== 10'b0001010000) begin
            n_fail++; $display("FAIL add: got state %0d vec %b expected 10 %b", state, vec, 10'b0001010000);
        end
        tick();
        goto_exec(OP_STORE);
        n_checks++;
        if (state !== 4'd9 || vec !== 10'b0001100000) begin
            n_fail++; $display("FAIL store: got state %0d vec %b expected 9 %b", state, vec, 10'b0001100000);
        end
        tick();
        n_checks++;
        if (state !== 4'd1 || MemWr !== 1'b0) begin
            n_fail++; $display("FAIL store_one_cycle: got state %0d MemWr %b expected 1 0", state, MemWr);
        end
    endtask

    task automatic test_input();
`ifdef CU_INPUT_WAIT_EN
        int loads;
        bit seen_fetch;
        enter = 1'b0;
        goto_exec(OP_INPUT);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (state !== 4'd12 || Aload !== 1'b0) begin
                n_fail++; $display("FAIL input_wait%0d: got state %0d Aload %b expected 12 0", i, state, Aload);
            end
            if (i < 4) tick();
        end
        enter = 1'b1;
        loads = 0;
        seen_fetch = 1'b0;
        for (int i = 0; i < 6 && !seen_fetch; i++) begin
            if (i == 3) enter = 1'b0;
            tick();
            if (state === 4'd1) seen_fetch = 1'b1;
            else if (Aload === 1'b1) loads++;
        end
        enter = 1'b0;
        n_checks++;
        if (loads != 1 || !seen_fetch) begin
            n_fail++; $display("FAIL input_fire: got %0d loads fetch=%0d expected 1 loads fetch=1", loads, seen_fetch);
        end
`else
        enter = 1'b0;
        goto_exec(OP_INPUT);
        n_checks++;
        if (state !== 4'd12 || vec !== 10'b0000010010) begin
            n_fail++; $display("FAIL input: got state %0d vec %b expected 12 %b", state, vec, 10'b0000010010);
        end
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL input_to_fetch: got %0d expected 1", state); end
`endif
    endtask

    task automatic test_reset_mid_instr();
        IR75 = OP_STORE;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd0 || MemWr !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got state %0d MemWr %b expected 0 0", state, MemWr);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL mid_reset_fetch: got %0d expected 1", state); end
    endtask

    task automatic test_halt();
        int bad;
        goto_exec(OP_HALT);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            IR75 = 3'(i);
            if (state !== 4'd15 || vec !== 10'b0000000001) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd0 || halt !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: got state %0d halt %b expected 0 0", state, halt);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL halt_restart: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_jumps();
        test_alu_store();
        test_input();
        test_reset_mid_instr();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
